seg7_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 3-digit common-anode seven-segment display. It holds a 12-bit hex value and drives one digit at a time at a refresh rate invisible to the eye. A blanking gap between digits prevents ghosting. Value updates take effect only at frame boundaries, so the display never shows a mix of old and new digits. It sits between application logic, such as counters and switch readers, and the display pins; it replaces direct static drive of a single digit.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_hex_font.sv | 19 +
 rtl/seg7_scan_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types and constants for the 3-digit seven-segment scanner
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low g..a patterns, entry 15 first down to entry 0
    localparam logic [15:0][6:0] HEX_FONT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_font.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_font
//  Purpose  : Combinational hex nibble to active-low seven-segment pattern
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = HEX_FONT[nibble];
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed, tear-free scan controller for a 3-digit
//             common-anode seven-segment display with leading-zero blanking
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] value_in,
    input  logic [2:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [6:0]  SevenSegment,
    output logic        SevenSegmentDp,
    output logic [2:0]  SevenSegmentEnable,
    output logic        frame_done
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [1:0]    LAST_IDX   = 2'(NUM_DIGITS - 1);
    localparam state_e        LEAD_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [11:0]     act_val_q, act_val_d;
    logic [2:0]      act_dp_q, act_dp_d;
    logic            act_lz_q, act_lz_d;
    logic [11:0]     pend_val_q, pend_val_d;
    logic [2:0]      pend_dp_q, pend_dp_d;
    logic            pend_lz_q, pend_lz_d;
    logic            pend_flag_q, pend_flag_d;

    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [2:0]      en_q, en_d;
    logic            frame_done_q, frame_done_d;

    logic            frame_end;
    logic [3:0]      nibble;
    logic            blank_digit;
    logic            dp_bit;
    logic [6:0]      font_seg;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = LEAD_STATE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == DIGIT_LAST) begin
                        state_d = LEAD_STATE;
                        idx_d   = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign frame_end = enable && (state_q == SHOW) && (idx_q == LAST_IDX) && (cnt_q == DIGIT_LAST);

    // Active registers only change while idle or at a frame boundary, so a
    // frame never mixes digits from two different values.
    always_comb begin
        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        act_lz_d    = act_lz_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_lz_d   = pend_lz_q;
        pend_flag_d = pend_flag_q;
        if (state_q == IDLE) begin
            if (load) begin
                act_val_d = value_in;
                act_dp_d  = dp_in;
                act_lz_d  = blank_lz;
            end
        end else if (frame_end) begin
            if (load) begin
                act_val_d = value_in;
                act_dp_d  = dp_in;
                act_lz_d  = blank_lz;
            end else if (pend_flag_q) begin
                act_val_d = pend_val_q;
                act_dp_d  = pend_dp_q;
                act_lz_d  = pend_lz_q;
            end
            pend_flag_d = 1'b0;
        end else if (load) begin
            pend_val_d  = value_in;
            pend_dp_d   = dp_in;
            pend_lz_d   = blank_lz;
            pend_flag_d = 1'b1;
        end
    end

    // Outputs are decoded from next-state values so they land on the same
    // edge as the state they belong to.
    always_comb begin
        nibble      = act_val_d[3:0];
        dp_bit      = act_dp_d[0];
        blank_digit = 1'b0;
        case (idx_d)
            2'd1: begin
                nibble      = act_val_d[7:4];
                dp_bit      = act_dp_d[1];
                blank_digit = act_lz_d && (act_val_d[11:4] == 8'h00);
            end
            2'd2: begin
                nibble      = act_val_d[11:8];
                dp_bit      = act_dp_d[2];
                blank_digit = act_lz_d && (act_val_d[11:8] == 4'h0);
            end
            default: begin
                nibble      = act_val_d[3:0];
                dp_bit      = act_dp_d[0];
                blank_digit = 1'b0;
            end
        endcase
    end

    seg7_hex_font u_font (
        .nibble (nibble),
        .seg_n  (font_seg)
    );

    always_comb begin
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        en_d         = 3'b111;
        frame_done_d = (state_d == SHOW) && (idx_d == LAST_IDX) && (cnt_d == DIGIT_LAST);
        if (state_d == SHOW) begin
            en_d = ~(3'b001 << idx_d);
            seg_d = blank_digit ? SEG_OFF : font_seg;
            dp_d  = ~dp_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            act_val_q    <= 12'h000;
            act_dp_q     <= 3'b000;
            act_lz_q     <= 1'b0;
            pend_val_q   <= 12'h000;
            pend_dp_q    <= 3'b000;
            pend_lz_q    <= 1'b0;
            pend_flag_q  <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            en_q         <= 3'b111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            pend_flag_q  <= pend_flag_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SevenSegment       = seg_q;
    assign SevenSegmentDp     = dp_q;
    assign SevenSegmentEnable = en_q;
    assign frame_done         = frame_done_q;

endmodule
`default_nettype wire
